// File: rtl/stack_exec_pkg.sv
// Shared constants for the stack execution unit: default parameters, opcodes,
// FSM state encoding and ALU operation encoding.
package stack_exec_pkg;

  localparam int WIDTH_DATA_DEF = 16;
  localparam int AWIDTH_DEF     = 5;
  localparam int OPW_DEF        = 5;

  localparam int OP_PUSH_I = 1;
  localparam int OP_POP    = 2;
  localparam int OP_DUP    = 3;
  localparam int OP_ADD    = 4;
  localparam int OP_SUB    = 5;
  localparam int OP_AND    = 6;
  localparam int OP_OR     = 7;
  localparam int OP_SWAP   = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

endpackage

// File: rtl/stack_alu.sv
// Combinational ALU for binary stack ops; computes (a op b) with a = NOS, b = TOS.
module stack_alu
  import stack_exec_pkg::*;
#(
  parameter int WIDTH_DATA = WIDTH_DATA_DEF
) (
  input  alu_op_e               op,
  input  logic [WIDTH_DATA-1:0] a,
  input  logic [WIDTH_DATA-1:0] b,
  output logic [WIDTH_DATA-1:0] result,
  output logic                  carry
);

  logic [WIDTH_DATA:0] wide;

  // The extra top bit is the carry-out for ADD and the borrow (a < b) for SUB.
  always_comb begin
    wide = '0;
    case (op)
      ALU_ADD: wide = {1'b0, a} + {1'b0, b};
      ALU_SUB: wide = {1'b0, a} - {1'b0, b};
      ALU_AND: wide = {1'b0, a & b};
      ALU_OR:  wide = {1'b0, a | b};
      default: wide = '0;
    endcase
    result = wide[WIDTH_DATA-1:0];
    carry  = wide[WIDTH_DATA];
  end

endmodule

// File: rtl/stack_exec_unit.sv
// Three-cycle stack machine: TOS lives in a register, deeper entries in memory.
// state | meaning
// IDLE  | ready for an instruction; done pulses here after a commit
// RD    | fetch next-on-stack from memory
// WR    | evaluate the instruction, commit on the edge back to IDLE
module stack_exec_unit
  import stack_exec_pkg::*;
#(
  parameter int WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int AWIDTH     = AWIDTH_DEF,
  parameter int OPW        = OPW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH_DATA-1:0] instruction,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic                  err_clr,
  output logic [WIDTH_DATA-1:0] top_data,
  output logic [AWIDTH:0]       depth,
  output logic                  done,
  output logic                  carry,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic                  err_opcode
);

  localparam int IMMW  = WIDTH_DATA - OPW;
  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_FULL = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] D_ONE      = (AWIDTH+1)'(1);
  localparam logic [AWIDTH:0] D_TWO      = (AWIDTH+1)'(2);

  state_e                state_q, state_d;
  logic [WIDTH_DATA-1:0] instr_q, instr_d;
  logic [WIDTH_DATA-1:0] nos_q, nos_d;
  logic [WIDTH_DATA-1:0] top_q, top_d;
  logic [AWIDTH:0]       depth_q, depth_d;
  logic                  done_q, done_d;
  logic                  carry_q, carry_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, opc_q, opc_d;

  logic [WIDTH_DATA-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic [AWIDTH-1:0]     mem_waddr;
  logic [WIDTH_DATA-1:0] mem_wdata;

  logic [OPW-1:0]        opcode;
  logic [WIDTH_DATA-1:0] imm_ext;
  logic [AWIDTH-1:0]     idx_tos, idx_nos;
  alu_op_e               alu_op;
  logic [WIDTH_DATA-1:0] alu_res;
  logic                  alu_carry;

  assign opcode  = instr_q[WIDTH_DATA-1 -: OPW];
  assign imm_ext = {{OPW{1'b0}}, instr_q[IMMW-1:0]};
  // Slot just below TOS (where TOS is spilled on a push) and the NOS slot.
  assign idx_tos = depth_q[AWIDTH-1:0] - AWIDTH'(1);
  assign idx_nos = depth_q[AWIDTH-1:0] - AWIDTH'(2);

  always_comb begin
    case (opcode)
      OPW'(OP_SUB): alu_op = ALU_SUB;
      OPW'(OP_AND): alu_op = ALU_AND;
      OPW'(OP_OR):  alu_op = ALU_OR;
      default:      alu_op = ALU_ADD;
    endcase
  end

  stack_alu #(.WIDTH_DATA(WIDTH_DATA)) u_alu (
    .op     (alu_op),
    .a      (nos_q),
    .b      (top_q),
    .result (alu_res),
    .carry  (alu_carry)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    nos_d     = nos_q;
    top_d     = top_q;
    depth_d   = depth_q;
    done_d    = 1'b0;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    opc_d     = opc_q;
    mem_we    = 1'b0;
    mem_waddr = idx_tos;
    mem_wdata = top_q;

    // Clear first so an error raised in the same cycle takes precedence.
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
      opc_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instruction;
          state_d = S_RD;
        end
      end
      S_RD: begin
        nos_d   = mem_q[idx_nos];
        state_d = S_WR;
      end
      S_WR: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        case (opcode)
          OPW'(OP_PUSH_I): begin
            if (depth_q == DEPTH_FULL) ovf_d = 1'b1;
            else begin
              mem_we  = (depth_q != '0);
              top_d   = imm_ext;
              depth_d = depth_q + D_ONE;
            end
          end
          OPW'(OP_POP): begin
            if (depth_q == '0) unf_d = 1'b1;
            else begin
              top_d   = (depth_q == D_ONE) ? '0 : nos_q;
              depth_d = depth_q - D_ONE;
            end
          end
          OPW'(OP_DUP): begin
            if (depth_q == '0) unf_d = 1'b1;
            else if (depth_q == DEPTH_FULL) ovf_d = 1'b1;
            else begin
              mem_we  = 1'b1;
              depth_d = depth_q + D_ONE;
            end
          end
          OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_AND), OPW'(OP_OR): begin
            if (depth_q < D_TWO) unf_d = 1'b1;
            else begin
              top_d   = alu_res;
              depth_d = depth_q - D_ONE;
              if (alu_op == ALU_ADD || alu_op == ALU_SUB) carry_d = alu_carry;
            end
          end
          OPW'(OP_SWAP): begin
            if (depth_q < D_TWO) unf_d = 1'b1;
            else begin
              mem_we    = 1'b1;
              mem_waddr = idx_nos;
              top_d     = nos_q;
            end
          end
          default: opc_d = 1'b1;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      nos_q   <= '0;
      top_q   <= '0;
      depth_q <= '0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      opc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      nos_q   <= nos_d;
      top_q   <= top_d;
      depth_q <= depth_d;
      done_q  <= done_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      opc_q   <= opc_d;
    end
  end

  // Entries are never visible above depth, so the memory needs no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign instr_ready   = (state_q == S_IDLE);
  assign top_data      = top_q;
  assign depth         = depth_q;
  assign done          = done_q;
  assign carry         = carry_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  assign err_opcode    = opc_q;

endmodule
